framebuffer_scanout: RTL and testbench



---
 rtl/types_pkg.sv | 23 ++
 rtl/framebuffer_scanout_vga_timing.sv | 72 +++++++
 rtl/framebuffer_scanout.sv | 215 +++++++++++++++++++++
 tb/tb_framebuffer_scanout.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// types_pkg: shared VGA 640x480@60 timing constants and the buffer-swap
// FSM state type used by framebuffer_scanout and vga_timing.
package types_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  typedef enum logic [1:0] {
    START   = 2'd0,
    DRAWING = 2'd1,
    READY   = 2'd2
  } swap_state_t;

endpackage

// File: rtl/framebuffer_scanout_vga_timing.sv
// vga_timing: free-running horizontal/vertical counters for the VGA raster.
// All outputs are combinational decodes of the counters (raw, undelayed).
//   clk          in   pixel clock
//   rstn         in   asynchronous active-low reset
//   hsync_raw    out  active-low horizontal sync
//   vsync_raw    out  active-low vertical sync
//   active       out  pixel inside the visible area
//   v_active     out  current line is a visible line
//   vblank_start out  first clock of vertical blanking (h=0, v=V_ACT)
//   line_end     out  last clock of a line
//   frame_end    out  last clock of a frame
module vga_timing
  import types_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic clk,
  input  logic rstn,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic active,
  output logic v_active,
  output logic vblank_start,
  output logic line_end,
  output logic frame_end
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SW + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACT);
  localparam logic [HW-1:0] H_SS     = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_ACT + H_FP + H_SW);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACT);
  localparam logic [VW-1:0] V_SS     = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_ACT + V_FP + V_SW);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign line_end     = (h_cnt == H_LAST);
  assign frame_end    = line_end && (v_cnt == V_LAST);
  assign v_active     = (v_cnt < V_ACT_L);
  assign active       = (h_cnt < H_ACT_L) && v_active;
  assign hsync_raw    = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vsync_raw    = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign vblank_start = (h_cnt == '0) && (v_cnt == V_ACT_L);

endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: streams a BUFFER_WIDTH x BUFFER_HEIGHT RGB444
// framebuffer to VGA, upscaled by SCALE per axis, and runs the double-buffer
// swap handshake with the drawing side.
//   clk           in   pixel clock
//   rstn          in   asynchronous active-low reset
//   read_en       out  buffer read strobe
//   read_addr     out  x + y*BUFFER_WIDTH
//   read_data     in   synchronous RAM data, valid one cycle after read_en
//   buffer_select out  buffer being displayed (writer uses the other one)
//   draw_start    out  one-cycle pulse after reset to begin the first frame
//   frame_done    in   writer finished, held high until acked
//   draw_ack      out  one-cycle pulse releasing the writer
//   hsync, vsync  out  active-low syncs
//   vga_de        out  active video
//   vga_r/g/b     out  colour, zero outside active video
// Pipeline: counters t, address t+1, RAM data t+2, pins t+3; syncs and de
// travel through the same three stages so they stay aligned with colour.
module framebuffer_scanout
  import types_pkg::*;
#(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int SCALE             = 4,
  parameter int H_ACT             = H_ACTIVE,
  parameter int H_FP              = H_FRONT,
  parameter int H_SW              = H_SYNC,
  parameter int H_BP              = H_BACK,
  parameter int V_ACT             = V_ACTIVE,
  parameter int V_FP              = V_FRONT,
  parameter int V_SW              = V_SYNC,
  parameter int V_BP              = V_BACK
) (
  input  logic                         clk,
  input  logic                         rstn,
  output logic                         read_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] read_data,
  output logic                         buffer_select,
  output logic                         draw_start,
  input  logic                         frame_done,
  output logic                         draw_ack,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         vga_de,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b
);

  localparam int AW    = BUFFER_ADDR_WIDTH;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [AW-1:0]    ROW_STEP = AW'(BUFFER_WIDTH);

  // Raw timing from the counter stage
  logic hsync_raw, vsync_raw, active, v_active;
  logic vblank_start, line_end, frame_end;

  vga_timing #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rstn         (rstn),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .active       (active),
    .v_active     (v_active),
    .vblank_start (vblank_start),
    .line_end     (line_end),
    .frame_end    (frame_end)
  );

  // ---------------- incremental address generator ----------------
  // x/sub_x track h_cnt/SCALE and h_cnt%SCALE; row_base/sub_y track the
  // buffer row. Kept in step with the counters so row_base + x is the
  // address of the pixel the counters point at in the same cycle.
  logic [SUB_W-1:0] sub_x_reg, sub_y_reg;
  logic [AW-1:0]    x_reg, row_base_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sub_x_reg    <= '0;
      sub_y_reg    <= '0;
      x_reg        <= '0;
      row_base_reg <= '0;
    end else if (frame_end) begin
      sub_x_reg    <= '0;
      sub_y_reg    <= '0;
      x_reg        <= '0;
      row_base_reg <= '0;
    end else if (line_end) begin
      sub_x_reg <= '0;
      x_reg     <= '0;
      if (v_active) begin
        if (sub_y_reg == SUB_LAST) begin
          sub_y_reg    <= '0;
          row_base_reg <= row_base_reg + ROW_STEP;
        end else begin
          sub_y_reg <= sub_y_reg + 1'b1;
        end
      end
    end else if (active) begin
      if (sub_x_reg == SUB_LAST) begin
        sub_x_reg <= '0;
        x_reg     <= x_reg + 1'b1;
      end else begin
        sub_x_reg <= sub_x_reg + 1'b1;
      end
    end
  end

  // ---------------- delay pipeline ----------------
  logic          read_en_reg;
  logic [AW-1:0] read_addr_reg;
  logic          hs_d1_reg, vs_d1_reg;
  logic          de_d2_reg, hs_d2_reg, vs_d2_reg;
  logic          vga_de_reg, hsync_reg, vsync_reg;
  logic [3:0]    r_reg, g_reg, b_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      read_en_reg   <= 1'b0;
      read_addr_reg <= '0;
      hs_d1_reg     <= 1'b1;
      vs_d1_reg     <= 1'b1;
      de_d2_reg     <= 1'b0;
      hs_d2_reg     <= 1'b1;
      vs_d2_reg     <= 1'b1;
      vga_de_reg    <= 1'b0;
      hsync_reg     <= 1'b1;
      vsync_reg     <= 1'b1;
      r_reg         <= 4'd0;
      g_reg         <= 4'd0;
      b_reg         <= 4'd0;
    end else begin
      // Stage 1: address and strobe
      read_en_reg <= active;
      if (active) begin
        read_addr_reg <= row_base_reg + x_reg;
      end
      hs_d1_reg <= hsync_raw;
      vs_d1_reg <= vsync_raw;
      // Stage 2: RAM is producing read_data for the stage-1 address
      de_d2_reg <= read_en_reg;
      hs_d2_reg <= hs_d1_reg;
      vs_d2_reg <= vs_d1_reg;
      // Stage 3: pins
      vga_de_reg <= de_d2_reg;
      hsync_reg  <= hs_d2_reg;
      vsync_reg  <= vs_d2_reg;
      r_reg      <= de_d2_reg ? read_data[11:8] : 4'd0;
      g_reg      <= de_d2_reg ? read_data[7:4]  : 4'd0;
      b_reg      <= de_d2_reg ? read_data[3:0]  : 4'd0;
    end
  end

  // ---------------- swap FSM ----------------
  swap_state_t state_reg;
  logic        draw_start_reg, draw_ack_reg, buffer_select_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= START;
      draw_start_reg    <= 1'b0;
      draw_ack_reg      <= 1'b0;
      buffer_select_reg <= 1'b0;
    end else begin
      draw_start_reg <= 1'b0;
      draw_ack_reg   <= 1'b0;
      case (state_reg)
        START: begin
          draw_start_reg <= 1'b1;
          state_reg      <= DRAWING;
        end
        DRAWING: begin
          // The writer only drops frame_done after it sees draw_ack, so the
          // level still present during the ack cycle belongs to the frame
          // just swapped and must not arm another swap.
          if (frame_done && !draw_ack_reg) begin
            if (vblank_start) begin
              buffer_select_reg <= ~buffer_select_reg;
              draw_ack_reg      <= 1'b1;
            end else begin
              state_reg <= READY;
            end
          end
        end
        READY: begin
          if (vblank_start) begin
            buffer_select_reg <= ~buffer_select_reg;
            draw_ack_reg      <= 1'b1;
            state_reg         <= DRAWING;
          end
        end
        default: state_reg <= START;
      endcase
    end
  end

  assign read_en       = read_en_reg;
  assign read_addr     = read_addr_reg;
  assign buffer_select = buffer_select_reg;
  assign draw_start    = draw_start_reg;
  assign draw_ack      = draw_ack_reg;
  assign hsync         = hsync_reg;
  assign vsync         = vsync_reg;
  assign vga_de        = vga_de_reg;
  assign vga_r         = r_reg;
  assign vga_g         = g_reg;
  assign vga_b         = b_reg;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout with a reduced raster (16x12 active from an
// 8x6 buffer at SCALE 2) so several whole frames fit in a short run.
// Expected pin values are computed directly from the frame position with
// division/modulo, and swap times from the next-vblank rule.
module tb_framebuffer_scanout;

  localparam int BW = 8, BH = 6, S = 2, AW = 6;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int VBLANK = VA * HT;

  logic          clk = 1'b0;
  logic          rstn;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [11:0]   read_data;
  logic          buffer_select, draw_start, frame_done, draw_ack;
  logic          hsync, vsync, vga_de;
  logic [3:0]    vga_r, vga_g, vga_b;

  framebuffer_scanout #(
    .BUFFER_WIDTH(BW), .BUFFER_HEIGHT(BH), .BUFFER_DATA_WIDTH(12),
    .BUFFER_ADDR_WIDTH(AW), .SCALE(S),
    .H_ACT(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rstn(rstn), .read_en(read_en), .read_addr(read_addr),
    .read_data(read_data), .buffer_select(buffer_select),
    .draw_start(draw_start), .frame_done(frame_done), .draw_ack(draw_ack),
    .hsync(hsync), .vsync(vsync), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model
  logic [11:0] mem [BW*BH];
  logic [11:0] ram_q;
  always @(posedge clk) if (read_en) ram_q <= mem[read_addr];
  assign read_data = ram_q;

  // Clock edges since reset release
  int c;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) c <= 0;
    else       c <= c + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %-14s c=%0d got=%0h want=%0h", tag, c, got, want);
    end
  endtask

  // Reference: position of counter time t within the raster
  function automatic bit active_at(int t);
    int f = t % FT;
    return ((f % HT) < HA) && ((f / HT) < VA);
  endfunction
  function automatic int addr_at(int t);
    int f = t % FT;
    return ((f % HT) / S) + ((f / HT) / S) * BW;
  endfunction
  function automatic bit hs_low_at(int t);
    int h = (t % FT) % HT;
    return (h >= HA + HF) && (h < HA + HF + HS);
  endfunction
  function automatic bit vs_low_at(int t);
    int v = (t % FT) / HT;
    return (v >= VA + VF) && (v < VA + VF + VS);
  endfunction
  function automatic int next_vblank(int t);
    int base = t - (t % FT) + VBLANK;
    return (base >= t) ? base : base + FT;
  endfunction

  // Swap expectations, written by the stimulus process only
  int exp_ack_c = -1;
  bit bs_base   = 1'b0;

  // Per-cycle monitor
  logic prev_bs = 1'b0;
  int   de_cnt, hs_cnt, vs_cnt, max_addr;
  always @(negedge clk) begin
    if (rstn && c > 0) begin
      bit e_re, e_de;
      e_re = active_at(c - 1);
      e_de = (c >= 3) && active_at(c - 3);
      check("draw_start", draw_start, c == 1);
      check("read_en", read_en, e_re);
      if (e_re) check("read_addr", read_addr, addr_at(c - 1));
      check("vga_de", vga_de, e_de);
      check("hsync", hsync, (c >= 3) ? !hs_low_at(c - 3) : 1'b1);
      check("vsync", vsync, (c >= 3) ? !vs_low_at(c - 3) : 1'b1);
      check("rgb", {vga_r, vga_g, vga_b}, e_de ? mem[addr_at(c - 3)] : 12'h000);
      if (c == 3) check("first_pix", {vga_r, vga_g, vga_b}, 12'hA5C);
      check("draw_ack", draw_ack, c == exp_ack_c);
      check("buffer_select", buffer_select,
            bs_base ^ ((exp_ack_c >= 0) && (c >= exp_ack_c)));
      if (buffer_select !== prev_bs) check("bs_while_de", vga_de, 1'b0);
      prev_bs <= buffer_select;
      // Whole-frame totals over the first frame after each reset release
      if (c == 1) begin
        de_cnt <= 0; hs_cnt <= 0; vs_cnt <= 0; max_addr <= 0;
      end else begin
        if (c >= 3 && c < FT + 3) begin
          de_cnt <= de_cnt + int'(vga_de);
          hs_cnt <= hs_cnt + int'(!hsync);
          vs_cnt <= vs_cnt + int'(!vsync);
        end
        if (c < FT + 1 && read_en && int'(read_addr) > max_addr) max_addr <= int'(read_addr);
      end
      if (c == FT + 3) begin
        check("de_per_frame", de_cnt, HA * VA);
        check("hs_low_total", hs_cnt, HS * VT);
        check("vs_low_total", vs_cnt, VS * HT);
        check("last_addr", max_addr, BW * BH - 1);
      end
    end
  end

  task automatic check_reset(input string tag);
    $display("reset check %s at time %0t", tag, $time);
    check("rst_read_en", read_en, 1'b0);
    check("rst_read_addr", read_addr, '0);
    check("rst_vga_de", vga_de, 1'b0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("rst_draw_ack", draw_ack, 1'b0);
    check("rst_draw_start", draw_start, 1'b0);
    check("rst_buf_sel", buffer_select, 1'b0);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
  endtask

  task automatic wait_c(input int target);
    while (c < target) @(negedge clk);
  endtask

  // Raise frame_done while counters sit at td; expect the ack at the next
  // vblank start at or after td, visible one clock later.
  task automatic do_swap(input int td, input string name);
    int  want;
    bit  seen;
    wait_c(td);
    want       = next_vblank(td) + 1;
    frame_done = 1'b1;
    exp_ack_c  = want;
    seen       = 1'b0;
    for (int k = 0; k < 2 * FT + 10 && !seen; k++) begin
      @(negedge clk);
      if (draw_ack === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      check("ack_time", c, want);
      $display("swap %s: frame_done at %0d, draw_ack at %0d (expected %0d), wait %0d clocks",
               name, td, c, want, c - td);
      #1;
      bs_base   = ~bs_base;
    end else begin
      check("ack_timeout", 1'b0, 1'b1);
      #1;
    end
    exp_ack_c  = -1;
    frame_done = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at c=%0d", c);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < BW * BH; i++) mem[i] = 12'($urandom);
    mem[0]     = 12'hA5C;
    rstn       = 1'b0;
    frame_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("power_on");
    #2 rstn = 1'b1;

    // Done mid-frame, on a visible line
    do_swap(6 * HT + int'($urandom_range(0, HA - 1)), "mid_frame");
    // Done exactly on vblank start: swap in that same cycle
    do_swap(FT + VBLANK, "same_cycle");
    // Done one clock late: waits a full frame
    do_swap(2 * FT + VBLANK + 1, "one_late");

    // Reset in the middle of a visible line of a later frame
    wait_c(4 * FT + 7 * HT + 5);
    #2 rstn = 1'b0;
    exp_ack_c  = -1;
    bs_base    = 1'b0;
    frame_done = 1'b0;
    #1 check_reset("mid_frame");
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;

    do_swap(3 * HT + int'($urandom_range(0, HA - 1)), "after_reset");
    wait_c(FT + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
